// File: rtl/sdrc_wb_pkg.sv
// Shared types and constants for the Wishbone master feeding the SDRAM controller.
// FSM state encoding and Wishbone cycle-type identifiers.
package sdrc_wb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_FIN  = 2'd2
  } wb_state_e;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

endpackage

// File: rtl/sdrc_wb_master_if.sv
// Requester-side command/data stream plus the Wishbone link toward the SDRAM controller.
// Handshakes: a transfer happens on a rising edge where both valid and ready are high; rdat has no ready.
interface sdrc_wb_master_if
  import sdrc_wb_pkg::*;
#(
  parameter int APP_AW      = 26,
  parameter int dw          = 32,
  parameter int BL_W        = 4,
  parameter int WFIFO_DEPTH = 16
);
  localparam int CW = $clog2(WFIFO_DEPTH) + 1;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [APP_AW-1:0] cmd_addr;
  logic              cmd_we;
  logic [BL_W-1:0]   cmd_len;
  logic [dw/8-1:0]   cmd_sel;
  logic              wdat_valid;
  logic              wdat_ready;
  logic [dw-1:0]     wdat_data;
  logic              rdat_valid;
  logic [dw-1:0]     rdat_data;
  logic              done;
  logic              err;
  logic              busy;
  logic              wb_cyc;
  logic              wb_stb;
  logic              wb_we;
  logic [APP_AW-1:0] wb_addr;
  logic [dw-1:0]     wb_dati;
  logic [dw/8-1:0]   wb_sel;
  logic [2:0]        wb_cti;
  logic              wb_ack;
  logic [dw-1:0]     wb_dato;
  wb_state_e         dbg_state;
  logic [CW-1:0]     dbg_wfifo_count;

  modport master (
    input  cmd_valid, cmd_addr, cmd_we, cmd_len, cmd_sel,
    input  wdat_valid, wdat_data,
    input  wb_ack, wb_dato,
    output cmd_ready, wdat_ready, rdat_valid, rdat_data, done, err, busy,
    output wb_cyc, wb_stb, wb_we, wb_addr, wb_dati, wb_sel, wb_cti,
    output dbg_state, dbg_wfifo_count
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_we, cmd_len, cmd_sel,
    output wdat_valid, wdat_data,
    output wb_ack, wb_dato,
    input  cmd_ready, wdat_ready, rdat_valid, rdat_data, done, err, busy,
    input  wb_cyc, wb_stb, wb_we, wb_addr, wb_dati, wb_sel, wb_cti,
    input  dbg_state, dbg_wfifo_count
  );

endinterface

// File: rtl/sdrc_wb_wfifo.sv
// First-word-fall-through write-data FIFO; pops may drop several entries at once.
// WFIFO_DEPTH is expected to be a power of two so pointers wrap naturally.
module sdrc_wb_wfifo #(
  parameter int dw          = 32,
  parameter int WFIFO_DEPTH = 16,
  localparam int AW = $clog2(WFIFO_DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  logic [dw-1:0] data_i,
  input  logic [CW-1:0] pop_n_i,
  output logic [dw-1:0] head_o,
  output logic [CW-1:0] count_o,
  output logic          full_o
);

  logic [dw-1:0] mem_q [WFIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok;

  assign full_o  = (count_q == CW'(WFIFO_DEPTH));
  assign push_ok = push_i && !full_o;
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push_ok);
    rd_ptr_d = rd_ptr_q + AW'(pop_n_i);
    count_d  = count_q + CW'(push_ok) - pop_n_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/sdrc_wb_master.sv
// Turns a command/data stream into Wishbone classic or incrementing bursts toward the SDRAM controller.
// Write bursts only start once every beat is already buffered, so the strobe never drops mid-burst.
module sdrc_wb_master
  import sdrc_wb_pkg::*;
#(
  parameter int APP_AW      = 26,
  parameter int dw          = 32,
  parameter int BL_W        = 4,
  parameter int WFIFO_DEPTH = 16,
  parameter int TO_CYC      = 255
) (
  input logic              wb_clk,
  input logic              wb_resetn,
  sdrc_wb_master_if.master bus
);

  localparam int CW = $clog2(WFIFO_DEPTH) + 1;
  localparam int TW = $clog2(TO_CYC + 1);

  localparam logic [1:0] IDLE = ST_IDLE;
  localparam logic [1:0] BUS  = ST_BUS;
  localparam logic [1:0] FIN  = ST_FIN;

  logic [1:0]        state_q, state_d;
  logic [APP_AW-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [dw/8-1:0]   sel_q, sel_d;
  logic [BL_W-1:0]   len_q, len_d;
  logic [BL_W-1:0]   cnt_q, cnt_d;
  logic [TW-1:0]     to_q, to_d;
  logic              err_q, err_d;
  logic              rvalid_q, rvalid_d;
  logic [dw-1:0]     rdata_q, rdata_d;
  logic              rdy_q;

  logic              in_bus, ack, cmd_ok;
  logic [CW-1:0]     fifo_pop_n, fifo_count;
  logic [dw-1:0]     fifo_head;
  logic              fifo_full;

  sdrc_wb_wfifo #(.dw(dw), .WFIFO_DEPTH(WFIFO_DEPTH)) u_wfifo (
    .clk_i   (wb_clk),
    .rst_ni  (wb_resetn),
    .push_i  (bus.wdat_valid),
    .data_i  (bus.wdat_data),
    .pop_n_i (fifo_pop_n),
    .head_o  (fifo_head),
    .count_o (fifo_count),
    .full_o  (fifo_full)
  );

  assign in_bus = (state_q == BUS);
  assign ack    = in_bus && bus.wb_ack;
  // rdy_q holds cmd_ready low while reset is applied, even though the FSM sits in IDLE.
  assign cmd_ok = rdy_q && (state_q == IDLE) &&
                  (!bus.cmd_we || int'(fifo_count) >= int'(bus.cmd_len) + 1);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    we_d       = we_q;
    sel_d      = sel_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    to_d       = to_q;
    err_d      = 1'b0;
    rvalid_d   = 1'b0;
    rdata_d    = rdata_q;
    fifo_pop_n = '0;
    case (state_q)
      IDLE: begin
        if (bus.cmd_valid && cmd_ok) begin
          addr_d  = bus.cmd_addr;
          we_d    = bus.cmd_we;
          sel_d   = bus.cmd_sel;
          len_d   = bus.cmd_len;
          cnt_d   = bus.cmd_len;
          to_d    = '0;
          state_d = BUS;
        end
      end
      BUS: begin
        if (ack) begin
          addr_d = addr_q + APP_AW'(dw / 8);
          cnt_d  = cnt_q - 1'b1;
          to_d   = '0;
          if (we_q) begin
            fifo_pop_n = CW'(1);
          end else begin
            rvalid_d = 1'b1;
            rdata_d  = bus.wb_dato;
          end
          if (cnt_q == '0) state_d = FIN;
        end else if (to_q == TW'(TO_CYC - 1)) begin
          // Abandon the burst and discard its unsent write beats so the FIFO lines up with the next command.
          state_d = IDLE;
          err_d   = 1'b1;
          to_d    = '0;
          if (we_q) fifo_pop_n = CW'(cnt_q) + CW'(1);
        end else begin
          to_d = to_q + 1'b1;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk or negedge wb_resetn) begin
    if (!wb_resetn) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      we_q     <= 1'b0;
      sel_q    <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      to_q     <= '0;
      err_q    <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rdy_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      sel_q    <= sel_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      to_q     <= to_d;
      err_q    <= err_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      rdy_q    <= 1'b1;
    end
  end

  assign bus.cmd_ready       = cmd_ok;
  assign bus.wdat_ready      = !fifo_full;
  assign bus.rdat_valid      = rvalid_q;
  assign bus.rdat_data       = rdata_q;
  assign bus.done            = (state_q == FIN);
  assign bus.err             = err_q;
  assign bus.busy            = (state_q != IDLE);
  assign bus.wb_cyc          = in_bus;
  assign bus.wb_stb          = in_bus;
  assign bus.wb_we           = in_bus && we_q;
  assign bus.wb_addr         = addr_q;
  assign bus.wb_dati         = (in_bus && we_q) ? fifo_head : '0;
  assign bus.wb_sel          = in_bus ? sel_q : '0;
  assign bus.wb_cti          = !in_bus        ? CTI_CLASSIC :
                               (len_q == '0)  ? CTI_CLASSIC :
                               (cnt_q != '0)  ? CTI_INCR    : CTI_EOB;
  assign bus.dbg_state       = wb_state_e'(state_q);
  assign bus.dbg_wfifo_count = fifo_count;

endmodule
